// File: rtl/nios_pio_pulse_out.sv
// ============================================================================
// Module   : nios_pio_pulse_out
// Brief    : Avalon-MM output PIO with atomic set/clear and an auto-clearing
//            pulse engine (built only when NIOS_PIO_PULSE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_pio_pulse_out #(
  parameter int unsigned WIDTH         = 32,
  parameter logic [31:0] RESET_VALUE   = 32'h0,
  parameter int unsigned CNT_W         = 16,
  parameter logic [31:0] PULSE_LEN_DEF = 32'd16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] c_DATA_RST = RESET_VALUE[WIDTH-1:0];

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] r_data;

  assign w_wr = chipselect & ~write_n;
  assign w_wd = writedata[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= c_DATA_RST;
    end else if (w_wr) begin
      case (address)
        3'd0:    r_data <= w_wd;
        3'd1:    r_data <= r_data | w_wd;
        3'd2:    r_data <= r_data & ~w_wd;
        default: r_data <= r_data;
      endcase
    end
  end

`ifdef NIOS_PIO_PULSE_EN
  localparam logic [CNT_W-1:0] c_PLEN_RST = PULSE_LEN_DEF[CNT_W-1:0];
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_pmask;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_plen;
  logic [CNT_W-1:0] w_load;
  logic             w_pulse_wr;

  assign w_pulse_wr = w_wr && (address == 3'd3);
  // A programmed length of 0 still yields a one-cycle pulse
  assign w_load     = (r_plen == '0) ? c_CNT_ONE : r_plen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pmask <= '0;
      r_cnt   <= '0;
    end else if (w_pulse_wr) begin
      r_pmask <= r_pmask | w_wd;
      r_cnt   <= w_load;
    end else if (r_cnt == c_CNT_ONE) begin
      r_pmask <= '0;
      r_cnt   <= '0;
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_plen <= c_PLEN_RST;
    end else if (w_wr && (address == 3'd4)) begin
      r_plen <= writedata[CNT_W-1:0];
    end
  end

  assign out_port = r_data | r_pmask;

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = r_data;
      3'd3:    readdata[WIDTH-1:0] = r_pmask;
      3'd4:    readdata[CNT_W-1:0] = r_plen;
      3'd5:    readdata[0]         = (r_cnt != '0);
      default: readdata            = '0;
    endcase
  end
`else
  assign out_port = r_data;

  always_comb begin
    readdata = '0;
    if (address == 3'd0) begin
      readdata[WIDTH-1:0] = r_data;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_nios_pio_pulse_out.sv
// ============================================================================
// Module   : tb_nios_pio_pulse_out
// Brief    : Directed self-checking bench for nios_pio_pulse_out; expectations
//            follow the NIOS_PIO_PULSE_EN build selection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nios_pio_pulse_out;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [31:0] out_port;

  int total = 0;
  int bad   = 0;

  nios_pio_pulse_out #(
    .WIDTH         (32),
    .RESET_VALUE   (32'h5),
    .CNT_W         (16),
    .PULSE_LEN_DEF (32'd16)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write spans exactly one rising edge; returns on the negedge after it
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_async", out_port, 32'h5);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_out", out_port, 32'h5);
    rd_chk("rst_data", 3'd0, 32'h5);
    rd_chk("rst_status", 3'd5, 32'h0);
`ifdef NIOS_PIO_PULSE_EN
    rd_chk("rst_plen", 3'd4, 32'd16);
`else
    rd_chk("rst_plen_absent", 3'd4, 32'h0);
`endif

    wr(3'd0, 32'hA5A5A5A5);
    chk("data_out", out_port, 32'hA5A5A5A5);
    rd_chk("data_rd", 3'd0, 32'hA5A5A5A5);

    wr(3'd0, 32'hF0);
    wr(3'd1, 32'h0F);
    chk("set_out", out_port, 32'hFF);
    wr(3'd2, 32'h81);
    chk("clr_out", out_port, 32'h7E);
    rd_chk("set_rd0", 3'd1, 32'h0);
    rd_chk("clr_rd0", 3'd2, 32'h0);
    rd_chk("clr_data", 3'd0, 32'h7E);

    wr(3'd6, 32'hFFFFFFFF);
    wr(3'd7, 32'hFFFFFFFF);
    chk("addr67_wr_ignored", out_port, 32'h7E);
    rd_chk("addr6_rd", 3'd6, 32'h0);
    rd_chk("addr7_rd", 3'd7, 32'h0);

`ifdef NIOS_PIO_PULSE_EN
    // Basic 3-cycle pulse
    wr(3'd0, 32'h0);
    wr(3'd4, 32'd3);
    rd_chk("plen_rd", 3'd4, 32'd3);
    wr(3'd3, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("pulse_hi", out_port, 32'h1);
      rd_chk("pulse_busy", 3'd5, 32'h1);
      @(negedge clk);
    end
    chk("pulse_end", out_port, 32'h0);
    rd_chk("pulse_idle", 3'd5, 32'h0);

    // Retrigger on the CNT==1 cycle
    wr(3'd4, 32'd4);
    wr(3'd3, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("retrig_pre", out_port, 32'h1);
      @(negedge clk);
    end
    chk("retrig_last", out_port, 32'h1);
    address = 3'd3; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("retrig_both", out_port, 32'h3);
      @(negedge clk);
    end
    chk("retrig_end", out_port, 32'h0);

    // Zero length behaves as one cycle
    wr(3'd4, 32'd0);
    rd_chk("plen0_rd", 3'd4, 32'h0);
    wr(3'd3, 32'h4);
    chk("len0_hi", out_port, 32'h4);
    rd_chk("len0_busy", 3'd5, 32'h1);
    @(negedge clk);
    chk("len0_end", out_port, 32'h0);
    rd_chk("len0_idle", 3'd5, 32'h0);

    // Pulse over a bit already held in DATA
    wr(3'd0, 32'h1);
    wr(3'd4, 32'd2);
    wr(3'd3, 32'h1);
    chk("ovl_hi", out_port, 32'h1);
    repeat (2) @(negedge clk);
    chk("ovl_after", out_port, 32'h1);
    rd_chk("ovl_data", 3'd0, 32'h1);
    rd_chk("ovl_pmask0", 3'd3, 32'h0);

    // CLR of DATA does not cut an in-flight pulse
    wr(3'd4, 32'd5);
    wr(3'd3, 32'h30);
    wr(3'd2, 32'h1);
    chk("clr_keeps_pulse", out_port, 32'h30);
    rd_chk("pmask_rd", 3'd3, 32'h30);

    // Asynchronous reset mid-pulse
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_out", out_port, 32'h5);
    @(negedge clk);
    rd_chk("rst_mid_status", 3'd5, 32'h0);
    rd_chk("rst_mid_pmask", 3'd3, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Empty-mask pulse still sets busy
    wr(3'd4, 32'd2);
    wr(3'd3, 32'h0);
    chk("wd0_out", out_port, 32'h5);
    rd_chk("wd0_busy", 3'd5, 32'h1);
    repeat (2) @(negedge clk);
    rd_chk("wd0_idle", 3'd5, 32'h0);
`else
    wr(3'd4, 32'd7);
    wr(3'd3, 32'hFF);
    wr(3'd5, 32'hFFFFFFFF);
    chk("nopulse_out", out_port, 32'h7E);
    @(negedge clk);
    chk("nopulse_out2", out_port, 32'h7E);
    rd_chk("nopulse_rd3", 3'd3, 32'h0);
    rd_chk("nopulse_rd4", 3'd4, 32'h0);
    rd_chk("nopulse_rd5", 3'd5, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
